scalar_mult_ctrl: RTL

//  Sequencer for ECC scalar multiplication Q = k*P over GF(p), left-to-right double-and-add.

---
 rtl/scalar_mult_ctrl.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/scalar_mult_ctrl.sv
// -----------------------------------------------------------------------------
// scalar_mult_ctrl
//   Sequencer for ECC scalar multiplication Q = k*P over GF(p), using
//   left-to-right double-and-add. It drives one point-doubling unit and one
//   point-addition unit through their reset/result/infinity handshakes.
//   The point at infinity is tracked locally and is never handed to a unit.
//
// Ports
//   clk, reset                : clock, synchronous active-high reset
//   start                     : request pulse, accepted only when idle
//   k, p, a, xp, yp           : scalar, modulus, curve coefficient, base point
//   unit_p, unit_a            : latched p and a, shared by both units
//   dbl_reset                 : doubler reset (high = hold/restart)
//   dbl_x1, dbl_y1            : doubler operand (current Q)
//   dbl_x3, dbl_y3            : doubler result
//   dbl_result, dbl_infinity  : doubler result valid / result is infinity
//   add_reset                 : adder reset (high = hold/restart)
//   add_x1, add_y1            : adder operand 1 (current Q)
//   add_x2, add_y2            : adder operand 2 (latched P)
//   add_x3, add_y3            : adder result
//   add_result, add_infinity  : adder result valid / result is infinity
//   xq, yq, q_infinity        : final result, held until the next run ends
//   busy                      : high from accepted start until done
//   done                      : one-cycle pulse when the result is valid
//   error                     : unit timeout seen; cleared on the next start
// -----------------------------------------------------------------------------
module scalar_mult_ctrl #(
  parameter int n       = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] k,
  input  logic [n-1:0] p,
  input  logic [n-1:0] a,
  input  logic [n-1:0] xp,
  input  logic [n-1:0] yp,
  output logic [n-1:0] unit_p,
  output logic [n-1:0] unit_a,
  output logic         dbl_reset,
  output logic [n-1:0] dbl_x1,
  output logic [n-1:0] dbl_y1,
  input  logic [n-1:0] dbl_x3,
  input  logic [n-1:0] dbl_y3,
  input  logic         dbl_result,
  input  logic         dbl_infinity,
  output logic         add_reset,
  output logic [n-1:0] add_x1,
  output logic [n-1:0] add_y1,
  output logic [n-1:0] add_x2,
  output logic [n-1:0] add_y2,
  input  logic [n-1:0] add_x3,
  input  logic [n-1:0] add_y3,
  input  logic         add_result,
  input  logic         add_infinity,
  output logic [n-1:0] xq,
  output logic [n-1:0] yq,
  output logic         q_infinity,
  output logic         busy,
  output logic         done,
  output logic         error
);

  localparam int IW = (n > 1) ? $clog2(n) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, SCAN, DBL_RST, DBL_WAIT, DBL_CAP, ADD_RST, ADD_WAIT, ADD_CAP, FIN
  } state_t;

  state_t         r_state, w_next_state;
  logic [n-1:0]   r_k, r_p, r_a, r_px, r_py;
  logic [n-1:0]   r_qx, r_qy;
  logic           r_qinf;
  logic [IW-1:0]  r_idx;
  logic [CW-1:0]  r_wdog;
  logic [n-1:0]   r_xq, r_yq;
  logic           r_q_inf_out;
  logic           r_error;

  logic [n-1:0]   w_qx_nxt, w_qy_nxt;
  logic           w_qinf_nxt;
  logic           w_bit_done;
  logic           w_timeout;
  logic           w_kbit;
  logic           w_wdog_last;

  assign w_kbit      = r_k[r_idx];
  assign w_wdog_last = (r_wdog == CW'(TIMEOUT - 1));

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_qx_nxt     = r_qx;
    w_qy_nxt     = r_qy;
    w_qinf_nxt   = r_qinf;
    w_bit_done   = 1'b0;
    w_timeout    = 1'b0;

    case (r_state)
      IDLE: if (start) w_next_state = SCAN;

      // While Q is infinity the doubling is a no-op, so leading zeros cost one
      // cycle each and the first set bit simply loads Q = P.
      SCAN: begin
        if (r_qinf) begin
          if (w_kbit) begin
            w_qx_nxt   = r_px;
            w_qy_nxt   = r_py;
            w_qinf_nxt = 1'b0;
          end
          w_bit_done = 1'b1;
        end else begin
          w_next_state = DBL_RST;
        end
      end

      DBL_RST: w_next_state = DBL_WAIT;

      DBL_WAIT: begin
        if (dbl_result || dbl_infinity) w_next_state = DBL_CAP;
        else if (w_wdog_last)           w_timeout    = 1'b1;
      end

      DBL_CAP: begin
        w_qx_nxt   = dbl_infinity ? '0 : dbl_x3;
        w_qy_nxt   = dbl_infinity ? '0 : dbl_y3;
        w_qinf_nxt = dbl_infinity;
        if (w_kbit && !dbl_infinity) begin
          w_next_state = ADD_RST;
        end else begin
          // Infinity + P is P; the adder is never given infinity.
          if (w_kbit) begin
            w_qx_nxt   = r_px;
            w_qy_nxt   = r_py;
            w_qinf_nxt = 1'b0;
          end
          w_bit_done = 1'b1;
        end
      end

      ADD_RST: w_next_state = ADD_WAIT;

      ADD_WAIT: begin
        if (add_result || add_infinity) w_next_state = ADD_CAP;
        else if (w_wdog_last)           w_timeout    = 1'b1;
      end

      ADD_CAP: begin
        w_qx_nxt   = add_infinity ? '0 : add_x3;
        w_qy_nxt   = add_infinity ? '0 : add_y3;
        w_qinf_nxt = add_infinity;
        w_bit_done = 1'b1;
      end

      FIN: w_next_state = IDLE;

      default: w_next_state = IDLE;
    endcase

    if (w_timeout) begin
      w_qx_nxt     = '0;
      w_qy_nxt     = '0;
      w_qinf_nxt   = 1'b1;
      w_next_state = FIN;
    end

    if (w_bit_done) w_next_state = (r_idx == '0) ? FIN : SCAN;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_k         <= '0;
      r_p         <= '0;
      r_a         <= '0;
      r_px        <= '0;
      r_py        <= '0;
      r_qx        <= '0;
      r_qy        <= '0;
      r_qinf      <= 1'b1;
      r_idx       <= '0;
      r_wdog      <= '0;
      r_xq        <= '0;
      r_yq        <= '0;
      r_q_inf_out <= 1'b1;
      r_error     <= 1'b0;
    end else begin
      if (r_state == IDLE && start) begin
        r_k     <= k;
        r_p     <= p;
        r_a     <= a;
        r_px    <= xp;
        r_py    <= yp;
        r_qx    <= '0;
        r_qy    <= '0;
        r_qinf  <= 1'b1;
        r_idx   <= IW'(n - 1);
        r_error <= 1'b0;
      end else begin
        r_qx   <= w_qx_nxt;
        r_qy   <= w_qy_nxt;
        r_qinf <= w_qinf_nxt;
        if (w_bit_done && r_idx != '0) r_idx <= r_idx - IW'(1);
      end

      // Watchdog restarts for every unit operation and only runs while waiting.
      if (r_state == DBL_RST || r_state == ADD_RST)
        r_wdog <= '0;
      else if (r_state == DBL_WAIT || r_state == ADD_WAIT)
        r_wdog <= r_wdog + CW'(1);

      if (w_timeout) r_error <= 1'b1;

      // Result registers load on the way into FIN so they are valid with done.
      if (w_next_state == FIN) begin
        r_xq        <= w_qinf_nxt ? '0 : w_qx_nxt;
        r_yq        <= w_qinf_nxt ? '0 : w_qy_nxt;
        r_q_inf_out <= w_qinf_nxt;
      end
    end
  end

  assign unit_p     = r_p;
  assign unit_a     = r_a;
  assign dbl_x1     = r_qx;
  assign dbl_y1     = r_qy;
  assign add_x1     = r_qx;
  assign add_y1     = r_qy;
  assign add_x2     = r_px;
  assign add_y2     = r_py;
  assign dbl_reset  = !(r_state == DBL_WAIT || r_state == DBL_CAP);
  assign add_reset  = !(r_state == ADD_WAIT || r_state == ADD_CAP);
  assign busy       = (r_state != IDLE) && (r_state != FIN);
  assign done       = (r_state == FIN);
  assign xq         = r_xq;
  assign yq         = r_yq;
  assign q_infinity = r_q_inf_out;
  assign error      = r_error;

endmodule
